// File: rtl/vend_pkg.sv
// vend_pkg: shared constants for the vend dispense sequencer.
//  - FSM state encoding (IDLE, MOTOR, GAP, COIN, FAULT)
//  - change-code constants CHG_R0/R5/R10/R15 (code value == number of 5 tk coins)
//  - coin value and product price expressed in coins
// Optional feature macro used by the top: REFUND_ON_FAULT_EN.
package vend_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MOTOR = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_COIN  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic [1:0] CHG_R0  = 2'b00;
  localparam logic [1:0] CHG_R5  = 2'b01;
  localparam logic [1:0] CHG_R10 = 2'b10;
  localparam logic [1:0] CHG_R15 = 2'b11;

  localparam int COIN_TK     = 5;
  localparam int PRICE_COINS = 3;

endpackage

// File: rtl/vend_dispense_seq_if.sv
// vend_dispense_seq_if: command channel from the vending FSM into the sequencer.
//  vend_valid  command present (driven by master)
//  vend_ready  sequencer can accept (driven by slave)
//  vend_buy    1 = dispense one product
//  vend_chg    change code, 0..3 coins of 5 tk
// Handshake: a command transfers on the rising clock edge where vend_valid and
// vend_ready are both 1. vend_buy/vend_chg are only sampled on that edge;
// vend_valid while vend_ready=0 has no effect, and nothing is queued.
interface vend_dispense_seq_if;
  logic       vend_valid;
  logic       vend_ready;
  logic       vend_buy;
  logic [1:0] vend_chg;

  modport master (output vend_valid, output vend_buy, output vend_chg, input vend_ready);
  modport slave  (input vend_valid, input vend_buy, input vend_chg, output vend_ready);
endinterface

// File: rtl/vend_timeout_timer.sv
// vend_timeout_timer: stall timer shared by the motor and hopper phases.
// Ports:
//  clock, reset  system clock, synchronous active-high reset
//  clear         restart from zero (asserted on every FSM state change)
//  enable        count this cycle (phase that can stall is active)
//  limit         value of the count on the last allowed cycle
//  expired       count has reached limit while enabled
// The count saturates at limit so a stalled phase cannot wrap and miss expiry.
module vend_timeout_timer #(
  parameter int TW = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] limit,
  output logic          expired
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != limit)) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = enable && (count_q == limit);

endmodule

// File: rtl/vend_dispense_seq.sv
// vend_dispense_seq: runs the product motor for one vend command, then pays
// change as 5 tk coins, one hopper handshake per coin. Stalls are timed out.
// Ports:
//  clock, reset  system clock, synchronous active-high reset
//  vend          command channel (slave side of vend_dispense_seq_if)
//  motor_on      drive product motor            motor_done  drop sensor (level)
//  coin_req      request one coin               coin_ack    coin ejected (pulse)
//  busy          not IDLE                       fault       sticky, reset clears
//  vend_count    products dispensed (wraps)     state_o     FSM state (debug)
// Macro REFUND_ON_FAULT_EN: a motor timeout refunds the price in coins and the
// block keeps running; without it a motor timeout parks the block in FAULT.
module vend_dispense_seq
  import vend_pkg::*;
#(
  parameter int MOTOR_TIMEOUT  = 1000,
  parameter int HOPPER_TIMEOUT = 500,
  parameter int TW             = 10
) (
  input  logic                      clock,
  input  logic                      reset,
  vend_dispense_seq_if.slave        vend,
  output logic                      motor_on,
  input  logic                      motor_done,
  output logic                      coin_req,
  input  logic                      coin_ack,
  output logic                      busy,
  output logic                      fault,
  output logic [7:0]                vend_count,
  output logic [2:0]                state_o
);

  localparam logic [TW-1:0] MOTOR_LIM  = TW'(MOTOR_TIMEOUT - 1);
  localparam logic [TW-1:0] HOPPER_LIM = TW'(HOPPER_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    owed_q, owed_d;      // coins still to pay, up to 3 change + 3 refund
  logic [7:0]    count_q, count_d;
  logic          fault_q, fault_d;
  logic          accept;
  logic          tmr_expired;
  logic [TW-1:0] tmr_limit;

  assign vend.vend_ready = (state_q == ST_IDLE) && !reset;
  assign accept          = vend.vend_valid && vend.vend_ready;

  assign tmr_limit = (state_q == ST_MOTOR) ? MOTOR_LIM : HOPPER_LIM;

  vend_timeout_timer #(.TW(TW)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  ((state_q == ST_MOTOR) || (state_q == ST_COIN)),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    owed_d  = owed_q;
    count_d = count_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owed_d = {1'b0, vend.vend_chg};
          // Change-only commands pass through GAP so coin_req timing matches
          // the post-motor path.
          if (vend.vend_buy)                 state_d = ST_MOTOR;
          else if (vend.vend_chg != CHG_R0)  state_d = ST_GAP;
        end
      end
      ST_MOTOR: begin
        // Sensor is checked before the timer so a drop on the last cycle counts.
        if (motor_done) begin
          count_d = count_q + 8'd1;
          state_d = ST_GAP;
        end else if (tmr_expired) begin
          fault_d = 1'b1;
`ifdef REFUND_ON_FAULT_EN
          owed_d  = owed_q + 3'(PRICE_COINS);
          state_d = ST_GAP;
`else
          state_d = ST_FAULT;
`endif
        end
      end
      ST_GAP: begin
        state_d = (owed_q != 3'd0) ? ST_COIN : ST_IDLE;
      end
      ST_COIN: begin
        if (coin_ack) begin
          owed_d  = owed_q - 3'd1;
          state_d = ST_GAP;
        end else if (tmr_expired) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owed_q  <= 3'd0;
      count_q <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owed_q  <= owed_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  assign motor_on   = (state_q == ST_MOTOR);
  assign coin_req   = (state_q == ST_COIN);
  assign busy       = (state_q != ST_IDLE);
  assign fault      = fault_q;
  assign vend_count = count_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_vend_dispense_seq.sv
// tb_vend_dispense_seq: directed and randomized stimulus for vend_dispense_seq,
// checked against a transaction-level model of each vend command.
// Build option REFUND_ON_FAULT_EN selects the refund behaviour in the model.
module tb_vend_dispense_seq;

  localparam int MOTOR_TIMEOUT  = 1000;
  localparam int HOPPER_TIMEOUT = 500;
  localparam int NEVER          = 5000;
`ifdef REFUND_ON_FAULT_EN
  localparam bit REFUND = 1'b1;
`else
  localparam bit REFUND = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       motor_on, motor_done, coin_req, coin_ack, busy, fault;
  logic [7:0] vend_count;
  logic [2:0] state_o;

  vend_dispense_seq_if vif ();

  vend_dispense_seq #(
    .MOTOR_TIMEOUT  (MOTOR_TIMEOUT),
    .HOPPER_TIMEOUT (HOPPER_TIMEOUT),
    .TW             (10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .vend       (vif),
    .motor_on   (motor_on),
    .motor_done (motor_done),
    .coin_req   (coin_req),
    .coin_ack   (coin_ack),
    .busy       (busy),
    .fault      (fault),
    .vend_count (vend_count),
    .state_o    (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  logic [7:0] m_count = 8'd0;
  bit         m_fault = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    vif.vend_valid  = 1'b0;
    motor_done      = 1'b0;
    coin_ack        = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    m_count = 8'd0;
    m_fault = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_ready"},  vif.vend_ready, 1);
    check({tag, "_busy"},   busy,           0);
    check({tag, "_motor"},  motor_on,       0);
    check({tag, "_coin"},   coin_req,       0);
    check({tag, "_fault"},  fault,          0);
    check({tag, "_count"},  vend_count,     0);
  endtask

  // One vend command: the model predicts the transaction outcome, the driver
  // plays motor sensor and hopper (md / ad = cycles of motor_on / coin_req
  // before the response) and measures what the DUT did.
  task automatic run_cmd(input string tag, input bit buy, input int chg,
                         input int md, input int ad);
    int owed, e_mcyc, e_rises, e_high, e_lat, e_gap;
    bit e_endfault;
    int mcyc, rises, high, lat, gap_max, low_run, overlap, j, quiet;
    bit prev_coin, ended;

    // reference model
    owed = chg; e_mcyc = 0; e_rises = 0; e_high = 0; e_endfault = 1'b0;
    e_lat = buy ? 1 : ((chg != 0) ? 2 : 0);
    if (buy) begin
      if (md < MOTOR_TIMEOUT) begin
        e_mcyc  = md + 1;
        m_count = m_count + 8'd1;
      end else begin
        e_mcyc  = MOTOR_TIMEOUT;
        m_fault = 1'b1;
        if (REFUND) owed = owed + 3;
        else begin
          e_endfault = 1'b1;
          owed       = 0;
        end
      end
    end
    if (owed > 0) begin
      if (ad < HOPPER_TIMEOUT) begin
        e_rises = owed;
        e_high  = owed * (ad + 1);
      end else begin
        e_rises    = 1;
        e_high     = HOPPER_TIMEOUT;
        m_fault    = 1'b1;
        e_endfault = 1'b1;
      end
    end
    e_gap = (e_rises >= 2) ? 1 : 0;

    // issue command
    vif.vend_valid = 1'b1;
    vif.vend_buy   = buy;
    vif.vend_chg   = 2'(chg);
    step();
    vif.vend_valid = 1'b0;

    mcyc = 0; rises = 0; high = 0; lat = 0; gap_max = 0; low_run = 0;
    overlap = 0; j = 0; quiet = 0; prev_coin = 1'b0; ended = 1'b0;
    for (int idx = 1; idx <= 4000 && !ended; idx++) begin
      if (motor_on && coin_req) overlap++;
      if ((motor_on || coin_req) && lat == 0) lat = idx;
      if (motor_on) mcyc++;
      if (coin_req && !prev_coin) begin
        rises++;
        if (rises >= 2 && low_run > gap_max) gap_max = low_run;
        j = 0;
      end
      if (coin_req) begin
        high++;
        j++;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_coin = coin_req;

      if (vif.vend_ready) ended = 1'b1;
      else begin
        quiet = (!motor_on && !coin_req) ? quiet + 1 : 0;
        if (quiet >= 3 && fault) ended = 1'b1;
      end

      if (!ended) begin
        motor_done     = motor_on ? (mcyc > md) : ($urandom_range(0, 7) == 0);
        coin_ack       = coin_req ? (j == ad + 1) : ($urandom_range(0, 7) == 0);
        vif.vend_valid = ($urandom_range(0, 3) == 0);
        vif.vend_buy   = 1'($urandom_range(0, 1));
        vif.vend_chg   = 2'($urandom_range(0, 3));
        step();
      end
    end
    vif.vend_valid = 1'b0;
    motor_done     = 1'b0;
    coin_ack       = 1'b0;

    check({tag, "_ended"},   ended,          1);
    check({tag, "_motor"},   mcyc,           e_mcyc);
    check({tag, "_coins"},   rises,          e_rises);
    check({tag, "_coinhi"},  high,           e_high);
    check({tag, "_lat"},     lat,            e_lat);
    check({tag, "_gap"},     gap_max,        e_gap);
    check({tag, "_overlap"}, overlap,        0);
    check({tag, "_ready"},   vif.vend_ready, !e_endfault);
    check({tag, "_fault"},   fault,          m_fault);
    check({tag, "_count"},   vend_count,     m_count);
  endtask

  task automatic wait_coin(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (coin_req) seen = 1'b1;
      else step();
    end
    check(tag, seen, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit act;
    vif.vend_valid = 1'b0;
    vif.vend_buy   = 1'b0;
    vif.vend_chg   = 2'b00;
    motor_done     = 1'b0;
    coin_ack       = 1'b0;
    do_reset();
    idle_checks("rst");

    run_cmd("t1_buy_chg5", 1'b1, 1, 5, 0);
    run_cmd("t2_chg10", 1'b0, 2, 0, 2);
    run_cmd("t5_done_at_expiry", 1'b1, 0, MOTOR_TIMEOUT - 1, 0);
    run_cmd("ack_at_expiry", 1'b0, 1, 0, HOPPER_TIMEOUT - 1);
    run_cmd("chg0_nobuy", 1'b0, 0, 0, 0);

    for (int n = 0; n < 40; n++)
      run_cmd("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(0, 12), $urandom_range(0, 6));

    // enough purchases to carry vend_count through 255 -> 0
    for (int n = 0; n < 260; n++)
      run_cmd("wrap", 1'b1, 0, $urandom_range(0, 2), 0);

    run_cmd("t3_motor_stall", 1'b1, 3, NEVER, 0);
    check("t3_coin_low", coin_req, 0);
    do_reset();
    idle_checks("t3_rst");

    run_cmd("t4_hopper_stall", 1'b0, 1, 0, NEVER);
    check("t4_coin_low", coin_req, 0);
    do_reset();
    idle_checks("t4_rst");

    // reset during the second coin of three (two still owed)
    vif.vend_valid = 1'b1;
    vif.vend_buy   = 1'b0;
    vif.vend_chg   = 2'b11;
    step();
    vif.vend_valid = 1'b0;
    wait_coin("t6_first_coin");
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    check("t6_after_ack", coin_req, 0);
    wait_coin("t6_second_coin");
    reset = 1'b1;
    step();
    check("t6_rst_coin", coin_req, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", vif.vend_ready, 0);
    reset = 1'b0;
    step();
    m_count = 8'd0;
    m_fault = 1'b0;
    idle_checks("t6_post");
    vif.vend_valid = 1'b1;
    vif.vend_buy   = 1'b0;
    vif.vend_chg   = 2'b00;
    step();
    vif.vend_valid = 1'b0;
    act = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (busy || motor_on || coin_req || !vif.vend_ready) act = 1'b1;
      step();
    end
    check("t6_null_cmd_quiet", act, 0);
    check("t6_null_cmd_fault", fault, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
